// File: rtl/eq2_lock_pkg.sv
// Shared types and constants for the eq2 lock detector.
// Provides the FSM state encoding, saturation limits and a saturating increment helper.
package eq2_lock_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SEARCH   = 2'd1,
    LOCKED   = 2'd2,
    HOLD     = 2'd3
  } lock_state_e;

  localparam logic [7:0]  RUN_MAX   = 8'd255;
  localparam logic [15:0] MATCH_MAX = 16'd65535;

  // Run length sticks at its maximum instead of wrapping back to zero
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == RUN_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/eq2_bit_cmp.sv
// Combinational 2-bit equality cell feeding the lock detector.
module eq2_bit_cmp (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);

  assign eq = (a[0] ~^ b[0]) & (a[1] ~^ b[1]);

endmodule

// File: rtl/eq2_lock_detector.sv
// Lock detector: tracks runs of equal 2-bit samples and declares/releases lock with hysteresis.
// Optional feature macro EQ2_LOCK_STATS_EN adds the saturating 16-bit match_cnt statistics port.
module eq2_lock_detector
  import eq2_lock_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [1:0]  a,
  input  logic [1:0]  b,
  output logic        locked,
  output logic        lock_pulse,
  output logic        unlock_pulse,
  output logic [7:0]  run_len
`ifdef EQ2_LOCK_STATS_EN
  ,
  output logic [15:0] match_cnt
`endif
);

  localparam logic [7:0] LOCK_TGT   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_TGT = 8'(UNLOCK_CNT);

  logic        eq;
  lock_state_e state, state_n;
  logic [7:0]  miss, miss_n;
  logic [7:0]  run_n;
  logic [7:0]  run_inc;
  logic        locked_n;
  logic        lock_pulse_n;
  logic        unlock_pulse_n;

  eq2_bit_cmp u_cmp (
    .a  (a),
    .b  (b),
    .eq (eq)
  );

  assign run_inc = sat_inc8(run_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= UNLOCKED;
      miss         <= 8'd0;
      run_len      <= 8'd0;
      locked       <= 1'b0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
    end else begin
      state        <= state_n;
      miss         <= miss_n;
      run_len      <= run_n;
      locked       <= locked_n;
      lock_pulse   <= lock_pulse_n;
      unlock_pulse <= unlock_pulse_n;
    end
  end

  // Invalid cycles fall through the defaults, so state and counters freeze and pulses drop
  always_comb begin
    state_n        = state;
    miss_n         = miss;
    run_n          = run_len;
    lock_pulse_n   = 1'b0;
    unlock_pulse_n = 1'b0;

    if (clear) begin
      state_n = UNLOCKED;
      miss_n  = 8'd0;
      run_n   = 8'd0;
    end else if (in_valid) begin
      unique case (state)
        UNLOCKED: begin
          if (eq) begin
            run_n = 8'd1;
            if (LOCK_CNT == 1) begin
              state_n      = LOCKED;
              lock_pulse_n = 1'b1;
            end else begin
              state_n = SEARCH;
            end
          end else begin
            run_n = 8'd0;
          end
        end
        SEARCH: begin
          if (eq) begin
            run_n = run_inc;
            if (run_inc == LOCK_TGT) begin
              state_n      = LOCKED;
              lock_pulse_n = 1'b1;
            end
          end else begin
            state_n = UNLOCKED;
            run_n   = 8'd0;
          end
        end
        LOCKED: begin
          if (eq) begin
            run_n = run_inc;
          end else begin
            run_n = 8'd0;
            if (UNLOCK_CNT == 1) begin
              state_n        = UNLOCKED;
              miss_n         = 8'd0;
              unlock_pulse_n = 1'b1;
            end else begin
              state_n = HOLD;
              miss_n  = 8'd1;
            end
          end
        end
        HOLD: begin
          if (eq) begin
            state_n = LOCKED;
            miss_n  = 8'd0;
            run_n   = 8'd1;
          end else if (miss + 8'd1 == UNLOCK_TGT) begin
            state_n        = UNLOCKED;
            miss_n         = 8'd0;
            unlock_pulse_n = 1'b1;
          end else begin
            miss_n = miss + 8'd1;
          end
        end
        default: begin
          state_n = UNLOCKED;
          miss_n  = 8'd0;
          run_n   = 8'd0;
        end
      endcase
    end

    locked_n = (state_n == LOCKED) || (state_n == HOLD);
  end

`ifdef EQ2_LOCK_STATS_EN
  logic [15:0] match_n;

  // Counts every accepted matching sample regardless of lock state
  always_comb begin
    match_n = match_cnt;
    if (clear) begin
      match_n = 16'd0;
    end else if (in_valid && eq && (match_cnt != MATCH_MAX)) begin
      match_n = match_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt <= 16'd0;
    end else begin
      match_cnt <= match_n;
    end
  end
`endif

endmodule

// File: tb/tb_eq2_lock_detector.sv
// Self-checking bench for eq2_lock_detector with default LOCK_CNT=4, UNLOCK_CNT=2.
module tb_eq2_lock_detector;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [1:0]  a;
  logic [1:0]  b;
  logic        locked;
  logic        lock_pulse;
  logic        unlock_pulse;
  logic [7:0]  run_len;
`ifdef EQ2_LOCK_STATS_EN
  logic [15:0] match_cnt;
  int          model_match;
`endif

  int checks;
  int errors;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [1:0] va;
    logic [1:0] vb;
    logic       exp_locked;
    logic       exp_lp;
    logic       exp_up;
    logic [7:0] exp_run;
  } vec_t;

  vec_t vecs[$];

  eq2_lock_detector #(.LOCK_CNT(4), .UNLOCK_CNT(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .locked       (locked),
    .lock_pulse   (lock_pulse),
    .unlock_pulse (unlock_pulse),
    .run_len      (run_len)
`ifdef EQ2_LOCK_STATS_EN
    ,
    .match_cnt    (match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and returns #1 after the capturing edge
  task automatic applyStimulus(input logic c, input logic v, input logic [1:0] x, input logic [1:0] y);
    clear    = c;
    in_valid = v;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic c, input logic v, input logic [1:0] x, input logic [1:0] y,
                        input logic lk, input logic lp, input logic up, input logic [7:0] r);
    vec_t t;
    t.clr = c; t.vld = v; t.va = x; t.vb = y;
    t.exp_locked = lk; t.exp_lp = lp; t.exp_up = up; t.exp_run = r;
    vecs.push_back(t);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    a        = 2'b00;
    b        = 2'b00;
`ifdef EQ2_LOCK_STATS_EN
    model_match = 0;
`endif

    // Lock sequence
    addVec(0, 1, 2'b10, 2'b10, 0, 0, 0, 8'd1);
    addVec(0, 1, 2'b10, 2'b10, 0, 0, 0, 8'd2);
    addVec(0, 1, 2'b10, 2'b10, 0, 0, 0, 8'd3);
    addVec(0, 1, 2'b10, 2'b10, 1, 1, 0, 8'd4);
    addVec(0, 1, 2'b00, 2'b00, 1, 0, 0, 8'd5);
    // Hold recovery, then unlock
    addVec(0, 1, 2'b01, 2'b11, 1, 0, 0, 8'd0);
    addVec(0, 1, 2'b11, 2'b11, 1, 0, 0, 8'd1);
    addVec(0, 1, 2'b10, 2'b11, 1, 0, 0, 8'd0);
    addVec(0, 1, 2'b00, 2'b10, 0, 0, 1, 8'd0);
    addVec(0, 1, 2'b01, 2'b10, 0, 0, 0, 8'd0);
    // Broken search, then lock
    addVec(0, 1, 2'b01, 2'b01, 0, 0, 0, 8'd1);
    addVec(0, 1, 2'b01, 2'b01, 0, 0, 0, 8'd2);
    addVec(0, 1, 2'b01, 2'b01, 0, 0, 0, 8'd3);
    addVec(0, 1, 2'b01, 2'b11, 0, 0, 0, 8'd0);
    addVec(0, 1, 2'b11, 2'b11, 0, 0, 0, 8'd1);
    addVec(0, 1, 2'b11, 2'b11, 0, 0, 0, 8'd2);
    addVec(0, 1, 2'b11, 2'b11, 0, 0, 0, 8'd3);
    addVec(0, 1, 2'b11, 2'b11, 1, 1, 0, 8'd4);
    // Clear beats a valid equal sample while locked
    addVec(1, 1, 2'b10, 2'b10, 0, 0, 0, 8'd0);
    // Valid gaps freeze state
    addVec(0, 1, 2'b10, 2'b10, 0, 0, 0, 8'd1);
    addVec(0, 0, 2'b00, 2'b11, 0, 0, 0, 8'd1);
    addVec(0, 1, 2'b00, 2'b00, 0, 0, 0, 8'd2);
    addVec(0, 0, 2'b10, 2'b10, 0, 0, 0, 8'd2);
    addVec(0, 0, 2'b01, 2'b10, 0, 0, 0, 8'd2);
    addVec(0, 1, 2'b01, 2'b01, 0, 0, 0, 8'd3);
    addVec(0, 0, 2'b01, 2'b01, 0, 0, 0, 8'd3);
    addVec(0, 1, 2'b10, 2'b10, 1, 1, 0, 8'd4);
    addVec(0, 0, 2'b10, 2'b10, 1, 0, 0, 8'd4);
    addVec(0, 0, 2'b01, 2'b10, 1, 0, 0, 8'd4);

    #12;
    checkOutput("reset_locked", {31'd0, locked}, 32'd0);
    checkOutput("reset_lock_pulse", {31'd0, lock_pulse}, 32'd0);
    checkOutput("reset_unlock_pulse", {31'd0, unlock_pulse}, 32'd0);
    checkOutput("reset_run_len", {24'd0, run_len}, 32'd0);
`ifdef EQ2_LOCK_STATS_EN
    checkOutput("reset_match_cnt", {16'd0, match_cnt}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].clr, vecs[i].vld, vecs[i].va, vecs[i].vb);
      checkOutput($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_locked});
      checkOutput($sformatf("vec%0d_lock_pulse", i), {31'd0, lock_pulse}, {31'd0, vecs[i].exp_lp});
      checkOutput($sformatf("vec%0d_unlock_pulse", i), {31'd0, unlock_pulse}, {31'd0, vecs[i].exp_up});
      checkOutput($sformatf("vec%0d_run_len", i), {24'd0, run_len}, {24'd0, vecs[i].exp_run});
`ifdef EQ2_LOCK_STATS_EN
      if (vecs[i].clr) model_match = 0;
      else if (vecs[i].vld && (vecs[i].va == vecs[i].vb)) model_match++;
      checkOutput($sformatf("vec%0d_match_cnt", i), {16'd0, match_cnt}, model_match);
`endif
    end

    // Asynchronous reset in the middle of a search
    applyStimulus(1, 0, 2'b00, 2'b00);
    applyStimulus(0, 1, 2'b11, 2'b11);
    applyStimulus(0, 1, 2'b11, 2'b11);
    checkOutput("search_run_len", {24'd0, run_len}, 32'd2);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_run_len", {24'd0, run_len}, 32'd0);
    checkOutput("async_rst_locked", {31'd0, locked}, 32'd0);
    checkOutput("async_rst_pulses", {30'd0, lock_pulse, unlock_pulse}, 32'd0);
`ifdef EQ2_LOCK_STATS_EN
    checkOutput("async_rst_match_cnt", {16'd0, match_cnt}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Saturation under a long continuous match
    for (int n = 1; n <= 300; n++) begin
      applyStimulus(0, 1, 2'b01, 2'b01);
      if (n == 4 || n == 254 || n == 255 || n == 256 || n == 300) begin
        checkOutput($sformatf("sat%0d_run_len", n), {24'd0, run_len}, (n < 255) ? n : 255);
        checkOutput($sformatf("sat%0d_locked", n), {31'd0, locked}, 32'd1);
        checkOutput($sformatf("sat%0d_lock_pulse", n), {31'd0, lock_pulse}, (n == 4) ? 32'd1 : 32'd0);
      end
    end
`ifdef EQ2_LOCK_STATS_EN
    checkOutput("sat_match_cnt", {16'd0, match_cnt}, 32'd300);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eq2_lock_detector.md
# eq2_lock_detector

Sequential stage directly downstream of the team's 2-bit equality comparator. It samples a stream of 2-bit operand pairs, evaluates per-sample equality, and tracks runs of consecutive equal samples. It declares a registered lock after `LOCK_CNT` consecutive matches and releases it after `UNLOCK_CNT` consecutive mismatches. Its outputs drive LED and status logic on the prototyping board.

## Interface
- `LOCK_CNT`, default 4: consecutive equal valid samples needed to lock. Legal range is 1..255.
- `UNLOCK_CNT`, default 2: consecutive unequal valid samples needed to unlock while locked. Legal range is 1..255.
- `clk`  input  1  system clock. Everything is sampled on the rising edge.
- `reset_n`  input  1  reset, asynchronous and active-low (one clock; polarity and synchronicity fixed).
- `clear`  input  1  synchronous clear. Highest priority after reset.
- `in_valid`  input  1  qualifies `a`/`b` this cycle.
- `a`  input  2  operand A.
- `b`  input  2  operand B.
- `locked`  output  1  lock status (registered).
- `lock_pulse`  output  1  one-cycle pulse on entry to lock.
- `unlock_pulse`  output  1  one-cycle pulse on loss of lock.
- `run_len`  output  8  current consecutive-equal run length, saturating at 255.
- `match_cnt`  output  16  total equal valid samples. Present only with `EQ2_LOCK_STATS_EN`.

## Operation
- Per-sample equality: `eq = (a[0]~^b[0]) & (a[1]~^b[1])`. It is only meaningful when `in_valid` = 1.
- Cycles with `in_valid` = 0 freeze all state, `run_len`, and the miss counter. Pulses are 0 on those cycles.
- The state machine has four states: UNLOCKED, SEARCH, LOCKED, HOLD. `locked` = 1 in LOCKED and HOLD.
- **UNLOCKED**
  - valid & eq: `run_len` = 1. Go to LOCKED with `lock_pulse` if `LOCK_CNT` = 1, otherwise go to SEARCH.
  - valid & !eq: stay, `run_len` = 0.
- **SEARCH**
  - valid & eq: `run_len`++. When the new value equals `LOCK_CNT`, go to LOCKED and assert `lock_pulse`.
  - valid & !eq: go to UNLOCKED, `run_len` = 0.
- **LOCKED**
  - valid & eq: `run_len`++, saturating at 255.
  - valid & !eq: `run_len` = 0, miss = 1. Go to UNLOCKED with `unlock_pulse` if `UNLOCK_CNT` = 1, otherwise go to HOLD.
- **HOLD**
  - valid & eq: go to LOCKED, miss = 0, `run_len` = 1.
  - valid & !eq: miss++. When the new value equals `UNLOCK_CNT`, go to UNLOCKED, assert `unlock_pulse`, and set miss = 0.
- The miss counter is 8 bits and internal.
- `clear` = 1 forces UNLOCKED and zeroes `run_len`, miss, and `match_cnt`. It generates no pulses, even if currently locked, and overrides a simultaneous valid sample.

## Timing
- All outputs are registered. A sample presented at edge N is reflected in the outputs after edge N, i.e. visible in cycle N+1.
- Lock latency from the first matching sample: `LOCK_CNT` valid samples, plus 1 cycle to the output.
- `lock_pulse` and `unlock_pulse` are high for exactly one cycle and are never both high in the same cycle.
- Reset values: `locked`=0, `lock_pulse`=0, `unlock_pulse`=0, `run_len`=0, `match_cnt`=0, state = UNLOCKED.
- Reset asserted mid-operation clears everything immediately, without waiting for `clk`.
- `run_len` holds at 255 under a continuous match and does not wrap.

## Configuration
- Macro: `EQ2_LOCK_STATS_EN`.
- **Defined:** the `match_cnt` port and its 16-bit counter exist.
  - The counter increments on every valid & eq sample in any state, saturates at 65535, and is zeroed by `clear`.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `eq2_lock_pkg` holds:
  - the state enum (UNLOCKED, SEARCH, LOCKED, HOLD), 2 bits;
  - the constants `RUN_MAX` = 255 and `MATCH_MAX` = 65535.
- Sub-module `eq2_bit_cmp`: a combinational 2-bit equality cell producing `eq`. It is instantiated once.
- The top level holds the state machine, `run_len`, miss counter, pulse generation, and the optional statistics counter.

## Test plan
All scenarios use the defaults `LOCK_CNT`=4 and `UNLOCK_CNT`=2.
1. **Lock sequence:** reset, then 4 valid samples a=2'b10, b=2'b10 → `lock_pulse` one cycle after the 4th; `locked`=1; `run_len`=4.
2. **Broken search:** 3 equal samples, then a=01, b=11 → `locked` stays 0; `run_len`=0; no pulse. Then 4 equal samples → lock.
3. **Hold recovery and unlock:**
   - While locked: 1 unequal then 1 equal → `locked` stays 1, no `unlock_pulse`, `run_len`=1.
   - Then 2 unequal → `unlock_pulse` once; `locked`=0.
4. **Valid gaps:** equal samples interleaved with `in_valid`=0 cycles → state frozen during gaps; lock after the 4th valid equal sample.
5. **Clear and reset priority:**
   - `clear` with valid equal while locked → `locked`=0 next cycle, no `unlock_pulse`, `run_len`=0.
   - `reset_n` low mid-SEARCH → all outputs 0 asynchronously.
6. **Saturation (with `EQ2_LOCK_STATS_EN` defined):** 300 consecutive equal samples → `run_len`=255, `match_cnt`=300; build without the macro compiles with no `match_cnt` port.
